// File: rtl/si_alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : si_alu_mc
// Brief    : Multi-cycle execute-stage ALU with branch/jump target resolution.
//            Single-cycle ops complete in one cycle. MUL uses an iterative
//            shift-add unit that retires MUL_BPC multiplier bits per cycle.
//            Results are held in an output register under valid/ready.
// Ports    : clk, rst (sync, active-high), flush_i
//            in_valid_i / in_ready_o           - request handshake
//            alu_opcode_i, operand_1_i/_2_i    - operation and sources
//            current_pc_i, branch/jump_offset_i - PC and sign-extended offsets
//            out_valid_o / out_ready_i         - result handshake
//            alu_result_o, control_en_o, control_pc_o - registered result
// Revision : 1.0 - initial release
// ============================================================================
module si_alu_mc #(
    parameter int REG_DW   = 32,
    parameter int INST_AW  = 32,
    parameter int ALUOP_DW = 5,
    parameter int MUL_BPC  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [ALUOP_DW-1:0] alu_opcode_i,
    input  logic [REG_DW-1:0]   operand_1_i,
    input  logic [REG_DW-1:0]   operand_2_i,
    input  logic [INST_AW-1:0]  current_pc_i,
    input  logic [INST_AW-1:0]  branch_offset_i,
    input  logic [INST_AW-1:0]  jump_offset_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [REG_DW-1:0]   alu_result_o,
    output logic                control_en_o,
    output logic [INST_AW-1:0]  control_pc_o
);

    localparam int MUL_STEPS = REG_DW / MUL_BPC;
    localparam int CNT_W     = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
    localparam int SHW       = $clog2(REG_DW);

    localparam logic [ALUOP_DW-1:0] c_op_add   = ALUOP_DW'(1);
    localparam logic [ALUOP_DW-1:0] c_op_mul   = ALUOP_DW'(2);
    localparam logic [ALUOP_DW-1:0] c_op_bne   = ALUOP_DW'(3);
    localparam logic [ALUOP_DW-1:0] c_op_jal   = ALUOP_DW'(4);
    localparam logic [ALUOP_DW-1:0] c_op_lui   = ALUOP_DW'(5);
    localparam logic [ALUOP_DW-1:0] c_op_auipc = ALUOP_DW'(6);
    localparam logic [ALUOP_DW-1:0] c_op_and   = ALUOP_DW'(7);
    localparam logic [ALUOP_DW-1:0] c_op_sll   = ALUOP_DW'(8);
    localparam logic [ALUOP_DW-1:0] c_op_slt   = ALUOP_DW'(9);
    localparam logic [ALUOP_DW-1:0] c_op_blt   = ALUOP_DW'(10);
    localparam logic [ALUOP_DW-1:0] c_op_sub   = ALUOP_DW'(11);
    localparam logic [ALUOP_DW-1:0] c_op_or    = ALUOP_DW'(12);
    localparam logic [ALUOP_DW-1:0] c_op_xor   = ALUOP_DW'(13);
    localparam logic [ALUOP_DW-1:0] c_op_srl   = ALUOP_DW'(14);
    localparam logic [ALUOP_DW-1:0] c_op_sra   = ALUOP_DW'(15);
    localparam logic [ALUOP_DW-1:0] c_op_sltu  = ALUOP_DW'(16);
    localparam logic [ALUOP_DW-1:0] c_op_beq   = ALUOP_DW'(17);
    localparam logic [ALUOP_DW-1:0] c_op_bge   = ALUOP_DW'(18);
    localparam logic [ALUOP_DW-1:0] c_op_bltu  = ALUOP_DW'(19);
    localparam logic [ALUOP_DW-1:0] c_op_bgeu  = ALUOP_DW'(20);
    localparam logic [ALUOP_DW-1:0] c_op_jalr  = ALUOP_DW'(21);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [REG_DW-1:0]    r_mul_a;
    logic [REG_DW-1:0]    r_mul_b;
    logic [REG_DW-1:0]    r_mul_acc;
    logic [INST_AW-1:0]   r_mul_pc4;
    logic                 r_out_valid;
    logic [REG_DW-1:0]    r_result;
    logic                 r_ctrl_en;
    logic [INST_AW-1:0]   r_ctrl_pc;

    logic                 w_accept;
    logic                 w_is_mul;
    logic [INST_AW-1:0]   w_pc4;
    logic [INST_AW-1:0]   w_br_tgt;
    logic [SHW-1:0]       w_shamt;
    logic                 w_take;
    logic [REG_DW-1:0]    w_res;
    logic                 w_cen;
    logic [INST_AW-1:0]   w_cpc;
    logic [REG_DW-1:0]    w_partial;
    logic [REG_DW-1:0]    w_mul_sum;

    // Accept only when idle and the output slot is empty or draining now.
    always_comb begin
        in_ready_o = !rst && (r_state == S_IDLE) && !flush_i &&
                     (!r_out_valid || out_ready_i);
    end

    assign w_accept  = in_valid_i && in_ready_o;
    assign w_is_mul  = (alu_opcode_i == c_op_mul);
    assign w_pc4     = current_pc_i + INST_AW'(4);
    assign w_br_tgt  = current_pc_i + branch_offset_i;
    assign w_shamt   = operand_2_i[SHW-1:0];

    // Single-cycle datapath; branches share the taken/not-taken target mux.
    always_comb begin
        w_res  = '0;
        w_cen  = 1'b0;
        w_cpc  = w_pc4;
        w_take = 1'b0;
        case (alu_opcode_i)
            c_op_add:   w_res = operand_1_i + operand_2_i;
            c_op_sub:   w_res = operand_1_i - operand_2_i;
            c_op_and:   w_res = operand_1_i & operand_2_i;
            c_op_or:    w_res = operand_1_i | operand_2_i;
            c_op_xor:   w_res = operand_1_i ^ operand_2_i;
            c_op_sll:   w_res = operand_1_i << w_shamt;
            c_op_srl:   w_res = operand_1_i >> w_shamt;
            c_op_sra:   w_res = $unsigned($signed(operand_1_i) >>> w_shamt);
            c_op_slt:   w_res = REG_DW'($signed(operand_1_i) < $signed(operand_2_i));
            c_op_sltu:  w_res = REG_DW'(operand_1_i < operand_2_i);
            c_op_lui:   w_res = operand_2_i;
            c_op_auipc: w_res = REG_DW'(current_pc_i) + operand_2_i;
            c_op_bne:   w_take = (operand_1_i != operand_2_i);
            c_op_beq:   w_take = (operand_1_i == operand_2_i);
            c_op_blt:   w_take = ($signed(operand_1_i) < $signed(operand_2_i));
            c_op_bge:   w_take = ($signed(operand_1_i) >= $signed(operand_2_i));
            c_op_bltu:  w_take = (operand_1_i < operand_2_i);
            c_op_bgeu:  w_take = (operand_1_i >= operand_2_i);
            c_op_jal: begin
                w_res = REG_DW'(w_pc4);
                w_cen = 1'b1;
                w_cpc = current_pc_i + jump_offset_i;
            end
            c_op_jalr: begin
                w_res = REG_DW'(w_pc4);
                w_cen = 1'b1;
                w_cpc = (INST_AW'(operand_1_i) + jump_offset_i) & ~INST_AW'(1);
            end
            default: ;
        endcase
        if (w_take) begin
            w_cen = 1'b1;
            w_cpc = w_br_tgt;
        end
    end

    // Partial products for the low MUL_BPC multiplier bits this step;
    // the multiplicand is pre-shifted in r_mul_a so no step index is needed.
    always_comb begin
        w_partial = '0;
        for (int k = 0; k < MUL_BPC; k++) begin
            if (r_mul_b[k]) begin
                w_partial = w_partial + (r_mul_a << k);
            end
        end
        w_mul_sum = r_mul_acc + w_partial;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_mul_acc   <= '0;
            r_mul_pc4   <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_ctrl_en   <= 1'b0;
            r_ctrl_pc   <= '0;
        end else if (flush_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_out_valid && out_ready_i) begin
                        r_out_valid <= 1'b0;
                    end
                    if (w_accept) begin
                        if (w_is_mul) begin
                            r_state   <= S_MULT;
                            r_cnt     <= '0;
                            r_mul_a   <= operand_1_i;
                            r_mul_b   <= operand_2_i;
                            r_mul_acc <= '0;
                            r_mul_pc4 <= w_pc4;
                        end else begin
                            r_out_valid <= 1'b1;
                            r_result    <= w_res;
                            r_ctrl_en   <= w_cen;
                            r_ctrl_pc   <= w_cpc;
                        end
                    end
                end
                S_MULT: begin
                    r_mul_acc <= w_mul_sum;
                    r_mul_a   <= r_mul_a << MUL_BPC;
                    r_mul_b   <= r_mul_b >> MUL_BPC;
                    r_cnt     <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(MUL_STEPS - 1)) begin
                        r_cnt       <= '0;
                        r_out_valid <= 1'b1;
                        r_result    <= w_mul_sum;
                        r_ctrl_en   <= 1'b0;
                        r_ctrl_pc   <= r_mul_pc4;
                        r_state     <= out_ready_i ? S_IDLE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (out_ready_i) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_valid_o  = r_out_valid;
    assign alu_result_o = r_result;
    assign control_en_o = r_ctrl_en;
    assign control_pc_o = r_ctrl_pc;

endmodule
`default_nettype wire

// File: tb/tb_si_alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_si_alu_mc
// Brief    : Directed self-checking bench for si_alu_mc (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_si_alu_mc;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [4:0]  alu_opcode_i;
    logic [31:0] operand_1_i;
    logic [31:0] operand_2_i;
    logic [31:0] current_pc_i;
    logic [31:0] branch_offset_i;
    logic [31:0] jump_offset_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] alu_result_o;
    logic        control_en_o;
    logic [31:0] control_pc_o;

    int n_checks = 0;
    int n_err    = 0;

    si_alu_mc u_dut (
        .clk             (clk),
        .rst             (rst),
        .flush_i         (flush_i),
        .in_valid_i      (in_valid_i),
        .in_ready_o      (in_ready_o),
        .alu_opcode_i    (alu_opcode_i),
        .operand_1_i     (operand_1_i),
        .operand_2_i     (operand_2_i),
        .current_pc_i    (current_pc_i),
        .branch_offset_i (branch_offset_i),
        .jump_offset_i   (jump_offset_i),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .alu_result_o    (alu_result_o),
        .control_en_o    (control_en_o),
        .control_pc_o    (control_pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pc;
        logic [31:0] boff;
        logic [31:0] joff;
        logic [31:0] res;
        logic        cen;
        logic [31:0] cpc;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] boff, input logic [31:0] joff);
        alu_opcode_i    = op;
        operand_1_i     = a;
        operand_2_i     = b;
        current_pc_i    = pc;
        branch_offset_i = boff;
        jump_offset_i   = joff;
        in_valid_i      = 1'b1;
    endtask

    // Present a request, confirm it is acceptable, and let it be taken.
    task automatic send(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] pc,
                        input logic [31:0] boff, input logic [31:0] joff);
        drive(op, a, b, pc, boff, joff);
        @(negedge clk);
        chk({tag, "_ready"}, 64'(in_ready_o), 64'd1);
        tick();
        in_valid_i = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] res,
                              input logic cen, input logic [31:0] cpc);
        @(negedge clk);
        chk({tag, "_valid"}, 64'(out_valid_o), 64'd1);
        chk({tag, "_res"},   64'(alu_result_o), 64'(res));
        chk({tag, "_cen"},   64'(control_en_o), 64'(cen));
        chk({tag, "_cpc"},   64'(control_pc_o), 64'(cpc));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        alu_opcode_i = '0; operand_1_i = '0; operand_2_i = '0;
        current_pc_i = '0; branch_offset_i = '0; jump_offset_i = '0;

        // pc=0x100, boff=0x40, joff=0x80 -> pc+4=0x104, btgt=0x140, jtgt=0x180
        vecs.push_back('{5'd1,  32'd7,          32'd5,          32'h8000_0000, 32'h40, 32'h80, 32'd12,         1'b0, 32'h8000_0004});
        vecs.push_back('{5'd11, 32'd5,          32'd7,          32'h100, 32'h40, 32'h80, 32'hFFFF_FFFE, 1'b0, 32'h104});
        vecs.push_back('{5'd7,  32'hF0F0,       32'hFF00,       32'h100, 32'h40, 32'h80, 32'hF000,      1'b0, 32'h104});
        vecs.push_back('{5'd12, 32'hF0F0,       32'h0F0F,       32'h100, 32'h40, 32'h80, 32'hFFFF,      1'b0, 32'h104});
        vecs.push_back('{5'd13, 32'hFF,         32'h0F,         32'h100, 32'h40, 32'h80, 32'hF0,        1'b0, 32'h104});
        vecs.push_back('{5'd8,  32'd1,          32'd36,         32'h100, 32'h40, 32'h80, 32'h10,        1'b0, 32'h104});
        vecs.push_back('{5'd14, 32'h8000_0000,  32'd4,          32'h100, 32'h40, 32'h80, 32'h0800_0000, 1'b0, 32'h104});
        vecs.push_back('{5'd9,  32'hFFFF_FFFF,  32'd1,          32'h100, 32'h40, 32'h80, 32'd1,         1'b0, 32'h104});
        vecs.push_back('{5'd16, 32'hFFFF_FFFF,  32'd1,          32'h100, 32'h40, 32'h80, 32'd0,         1'b0, 32'h104});
        vecs.push_back('{5'd5,  32'h5,          32'h1234_5000,  32'h100, 32'h40, 32'h80, 32'h1234_5000, 1'b0, 32'h104});
        vecs.push_back('{5'd6,  32'h5,          32'h1000,       32'h100, 32'h40, 32'h80, 32'h1100,      1'b0, 32'h104});
        vecs.push_back('{5'd0,  32'h9,          32'h9,          32'h100, 32'h40, 32'h80, 32'd0,         1'b0, 32'h104});
        vecs.push_back('{5'd25, 32'h9,          32'h9,          32'h100, 32'h40, 32'h80, 32'd0,         1'b0, 32'h104});
        vecs.push_back('{5'd3,  32'd3,          32'd3,          32'h100, 32'h40, 32'h80, 32'd0,         1'b0, 32'h104});
        vecs.push_back('{5'd17, 32'd3,          32'd3,          32'h100, 32'h40, 32'h80, 32'd0,         1'b1, 32'h140});
        vecs.push_back('{5'd18, 32'hFFFF_FFFF,  32'd1,          32'h100, 32'h40, 32'h80, 32'd0,         1'b0, 32'h104});
        vecs.push_back('{5'd20, 32'hFFFF_FFFF,  32'd1,          32'h100, 32'h40, 32'h80, 32'd0,         1'b1, 32'h140});
        vecs.push_back('{5'd10, 32'hFFFF_FFFF,  32'd1,          32'h8000_0010, 32'hFFFF_FFF0, 32'h0, 32'd0, 1'b1, 32'h8000_0000});
        vecs.push_back('{5'd19, 32'hFFFF_FFFF,  32'd1,          32'h8000_0010, 32'hFFFF_FFF0, 32'h0, 32'd0, 1'b0, 32'h8000_0014});
        vecs.push_back('{5'd4,  32'h0,          32'h0,          32'h100, 32'h40, 32'h80, 32'h104,       1'b1, 32'h180});
        vecs.push_back('{5'd21, 32'h8000_0101,  32'h0,          32'h8000_0020, 32'h0, 32'h4, 32'h8000_0024, 1'b1, 32'h8000_0104});

        // Reset state
        tick(); tick();
        @(negedge clk);
        chk("rst_ready_low", 64'(in_ready_o), 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready",  64'(in_ready_o),   64'd1);
        chk("rst_valid",  64'(out_valid_o),  64'd0);
        chk("rst_res",    64'(alu_result_o), 64'd0);
        chk("rst_cen",    64'(control_en_o), 64'd0);
        chk("rst_cpc",    64'(control_pc_o), 64'd0);
        tick();

        // Single-cycle vectors
        foreach (vecs[i]) begin
            send($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                 vecs[i].pc, vecs[i].boff, vecs[i].joff);
            expect_out($sformatf("v%0d", i), vecs[i].res, vecs[i].cen, vecs[i].cpc);
            tick();
            @(negedge clk);
            chk($sformatf("v%0d_drained", i), 64'(out_valid_o), 64'd0);
            tick();
        end

        // MUL latency, in_ready low for 8 cycles, back-to-back ADD on drain edge
        send("mul1", 5'd2, 32'hFFFF_FFFF, 32'd3, 32'h200, 32'h0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("mul1_busy%0d", i), 64'(in_ready_o), 64'd0);
            chk($sformatf("mul1_nov%0d", i),  64'(out_valid_o), 64'd0);
            tick();
        end
        drive(5'd1, 32'd2, 32'd3, 32'h300, 32'h0, 32'h0);
        expect_out("mul1", 32'hFFFF_FFFD, 1'b0, 32'h204);
        chk("b2b_ready", 64'(in_ready_o), 64'd1);
        tick();
        in_valid_i = 1'b0;
        expect_out("b2b_add", 32'd5, 1'b0, 32'h304);
        tick();

        // Back-pressure on SRA result
        out_ready_i = 1'b0;
        send("sra", 5'd15, 32'h8000_0000, 32'd4, 32'h100, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            expect_out($sformatf("sra_hold%0d", i), 32'hF800_0000, 1'b0, 32'h104);
            chk($sformatf("sra_ready%0d", i), 64'(in_ready_o), 64'd0);
            tick();
        end
        out_ready_i = 1'b1;
        @(negedge clk);
        chk("sra_drain_ready", 64'(in_ready_o), 64'd1);
        tick();
        @(negedge clk);
        chk("sra_drained", 64'(out_valid_o), 64'd0);
        tick();

        // Flush in MULT step 3 with a simultaneous request
        send("mulf", 5'd2, 32'd5, 32'd6, 32'h100, 32'h0, 32'h0);
        tick(); tick(); tick();
        flush_i = 1'b1;
        drive(5'd1, 32'd1, 32'd1, 32'h100, 32'h0, 32'h0);
        @(negedge clk);
        chk("flush_ready_low", 64'(in_ready_o), 64'd0);
        tick();
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        @(negedge clk);
        chk("flush_ready", 64'(in_ready_o), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("flush_nov%0d", i), 64'(out_valid_o), 64'd0);
            tick();
        end

        // MUL completing under back-pressure, held, then drained
        out_ready_i = 1'b0;
        send("mulw", 5'd2, 32'h1234, 32'h5678, 32'h400, 32'h0, 32'h0);
        for (int i = 0; i < 8; i++) tick();
        for (int i = 0; i < 3; i++) begin
            expect_out($sformatf("mulw%0d", i), 32'h0626_0060, 1'b0, 32'h404);
            chk($sformatf("mulw_ready%0d", i), 64'(in_ready_o), 64'd0);
            tick();
        end
        out_ready_i = 1'b1;
        tick();
        @(negedge clk);
        chk("mulw_drained", 64'(out_valid_o), 64'd0);
        chk("mulw_idle",    64'(in_ready_o),  64'd1);
        tick();

        // Reset in MULT step 3 with a simultaneous request
        send("mulr", 5'd2, 32'd9, 32'd9, 32'h100, 32'h0, 32'h0);
        tick(); tick(); tick();
        rst = 1'b1;
        drive(5'd1, 32'd1, 32'd1, 32'h100, 32'h0, 32'h0);
        @(negedge clk);
        chk("rstm_ready_low", 64'(in_ready_o), 64'd0);
        tick();
        rst = 1'b0;
        in_valid_i = 1'b0;
        @(negedge clk);
        chk("rstm_valid", 64'(out_valid_o),  64'd0);
        chk("rstm_res",   64'(alu_result_o), 64'd0);
        chk("rstm_cen",   64'(control_en_o), 64'd0);
        chk("rstm_cpc",   64'(control_pc_o), 64'd0);
        chk("rstm_ready", 64'(in_ready_o),   64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("rstm_nov%0d", i), 64'(out_valid_o), 64'd0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/si_alu_mc.md
# si_alu_mc

Parametrised multi-cycle successor of the single-issue ALU for the scalar core's execute stage. Accepts one operation per handshake and resolves branch/jump targets. Runs single-cycle ops in one cycle and multiplies with an iterative shift-add unit. Results are held in an output register under valid/ready flow control, so the stage can stall on a busy multiplier or a blocked write-back.

## Interface
- REG_DW, 32, operand/result width; power of two, ≥ 8
- INST_AW, 32, PC/offset width
- ALUOP_DW, 5, opcode width
- MUL_BPC, 4, multiplier bits retired per cycle; divides REG_DW; MUL_STEPS = REG_DW/MUL_BPC
- clk  in  1  clock; single clock domain, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- flush_i  in  1  discard in-flight op and pending result
- in_valid_i  in  1  request valid
- in_ready_o  out  1  unit can accept
- alu_opcode_i  in  ALUOP_DW  operation
- operand_1_i, operand_2_i  in  REG_DW  sources (operand_1 = rs1 for JALR)
- current_pc_i  in  INST_AW  PC of the op
- branch_offset_i, jump_offset_i  in  INST_AW  sign-extended offsets
- out_valid_o  out  1  result held
- out_ready_i  in  1  consumer takes result
- alu_result_o  out  REG_DW  result
- control_en_o  out  1  redirect taken (qualified by out_valid_o)
- control_pc_o  out  INST_AW  redirect target

## Operation
- Opcodes: 0 NOP, 1 ADD, 2 MUL, 3 BNE, 4 JAL, 5 LUI, 6 AUIPC, 7 AND, 8 SLL, 9 SLT, 10 BLT, 11 SUB, 12 OR, 13 XOR, 14 SRL, 15 SRA, 16 SLTU, 17 BEQ, 18 BGE, 19 BLTU, 20 BGEU, 21 JALR. Opcodes 22–31 behave as NOP.
- Arithmetic wraps modulo 2^REG_DW.
- Shift amount = operand_2_i[log2(REG_DW)-1:0].
- SLT/BLT/BGE are signed; SLTU/BLTU/BGEU are unsigned. SLT/SLTU return 1 or 0.
- LUI result = operand_2_i. AUIPC result = pc + operand_2_i.
- MUL result = low REG_DW bits of the product (same for signed and unsigned).
- Branch ops:
  - result = 0.
  - control_en = compare true.
  - control_pc = pc + branch_offset when taken, else pc + 4.
- JAL:
  - result = pc + 4.
  - control_en = 1.
  - control_pc = pc + jump_offset.
- JALR:
  - result = pc + 4.
  - control_en = 1.
  - control_pc = (operand_1 + jump_offset) & ~1.
- NOP: result 0, control_en 0, control_pc = pc + 4, still produces out_valid.
- FSM states:
  - IDLE: non-MUL accept → IDLE with output register loaded; MUL accept → MULT with operands latched and step counter = 0.
  - MULT: each cycle adds MUL_BPC partial products and increments the counter. When counter = MUL_STEPS-1, load the output register and go to WAIT if !in_ready_o-type stall applies, else IDLE.
  - WAIT: output register full and not drained; → IDLE when out_ready_i.
- in_ready_o = state==IDLE && !flush_i && (!out_valid_o || out_ready_i). This gives one op per cycle at full throughput.
- Output register updates only on load. It is stable while out_valid_o && !out_ready_i.
- flush_i:
  - Next cycle: out_valid_o = 0 and state = IDLE.
  - Aborts MULT mid-iteration.
  - Flush wins over a simultaneous in_valid_i; that request is not accepted.
- rst mid-MULT: same effect as flush, plus outputs cleared.

## Timing
- Reset values:
  - in_ready_o 1 after reset (0 while rst high).
  - out_valid_o 0, alu_result_o 0, control_en_o 0, control_pc_o 0.
  - state IDLE, step counter 0.
- Accept in cycle N (in_valid_i && in_ready_o at the edge closing N):
  - Single-cycle op: out_valid_o high in N+1.
  - MUL: out_valid_o high in N+1+MUL_STEPS (9 with defaults). in_ready_o low during N+1 … N+MUL_STEPS.
- Result leaves on the edge where out_valid_o && out_ready_i.
- A new op accepted on that same edge appears in the next cycle, with no bubble.
- Back-pressure: out_valid_o and all result fields hold unchanged for any number of cycles with out_ready_i low.
- control_en_o and control_pc_o are registered, aligned with out_valid_o. They are never asserted combinationally from inputs.

## Test plan
- Reset then ADD 7+5, pc=0x8000_0000, out_ready=1 → next cycle out_valid=1, result=12, control_en=0.
- MUL 0xFFFF_FFFF×3 (defaults) → in_ready low 8 cycles; out_valid 9 cycles after accept with result 0xFFFF_FFFD; back-to-back ADD accepted on the drain edge.
- BLT −1 vs 1, pc=0x8000_0010, offset=0xFFFF_FFF0 → control_en=1, control_pc=0x8000_0000. BLTU with the same operands → control_en=0, control_pc=0x8000_0014.
- JALR op1=0x8000_0101, offset=4, pc=0x8000_0020 → result 0x8000_0024, control_pc 0x8000_0104.
- out_ready low 5 cycles after SRA 0x8000_0000 >> 4 → result 0xF800_0000 held stable, in_ready=0; drains when out_ready rises.
- flush_i in MULT step 3, with in_valid also high → no out_valid, request not accepted, in_ready=1 the following cycle. Repeat with rst instead → all outputs 0.
